// File: rtl/bt_frame_assembler_pkg.sv
// Shared constants, state encoding and small helpers for the BlueTooth
// sensor frame assembler.
package bt_frame_assembler_pkg;

  localparam int         BT_DATA_WIDTH     = 8;
  localparam int         BT_FRAME_BYTES    = 11;
  localparam logic [7:0] BT_HEADER         = 8'h55;
  localparam int         BT_TIMEOUT_CYCLES = 500000;
  localparam int         BT_CNT_WIDTH      = 16;

  // Width of one assembled frame word (header byte in the MSBs).
  localparam int         BT_FRAME_WIDTH    = BT_FRAME_BYTES * BT_DATA_WIDTH;

  typedef enum logic [1:0] {
    BT_FRM_HUNT    = 2'd0,
    BT_FRM_COLLECT = 2'd1,
    BT_FRM_CHECK   = 2'd2,
    BT_FRM_OUTPUT  = 2'd3
  } bt_frm_state_e;

  // Bit offset of byte 'idx' inside the frame word; byte 0 sits at the top.
  function automatic int bt_frame_bit_lo(input int idx, input int frame_bytes,
                                         input int data_width);
    return (frame_bytes - 1 - idx) * data_width;
  endfunction

endpackage

// File: rtl/bt_frame_watchdog.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and emits
// a single-cycle expire pulse when the limit is reached.
module bt_frame_watchdog
  import bt_frame_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = BT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A clear always beats an expiry, so a byte landing on the last cycle wins.
  assign expire = en && !clr && (cnt_q == LIMIT);

  // Next count: restart on clear or expiry, advance only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bt_frame_assembler.sv
// Rebuilds fixed-length sensor frames (header, payload, 8-bit sum checksum)
// from the response FIFO byte stream and hands good frames downstream on a
// valid/ready handshake. Bad or stalled frames are dropped and counted.
module bt_frame_assembler
  import bt_frame_assembler_pkg::*;
#(
  parameter int                    DATA_WIDTH     = BT_DATA_WIDTH,
  parameter int                    FRAME_BYTES    = BT_FRAME_BYTES,
  parameter logic [DATA_WIDTH-1:0] HEADER         = DATA_WIDTH'(BT_HEADER),
  parameter int                    TIMEOUT_CYCLES = BT_TIMEOUT_CYCLES,
  parameter int                    CNT_WIDTH      = BT_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              fifo_r_en,
  input  logic [DATA_WIDTH-1:0]             fifo_data_i,
  input  logic                              fifo_data_i_vld,
  input  logic                              fifo_empty,
  output logic [FRAME_BYTES*DATA_WIDTH-1:0] frame_o,
  output logic                              frame_vld,
  input  logic                              frame_rdy,
  output logic                              err_checksum,
  output logic                              err_timeout,
  output logic [CNT_WIDTH-1:0]              frame_cnt,
  output logic [CNT_WIDTH-1:0]              drop_cnt
);

  localparam int               FRAME_W  = FRAME_BYTES * DATA_WIDTH;
  localparam int               IDX_W    = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  bt_frm_state_e         state_q, state_d;
  logic                  pending_q, pending_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
  logic [DATA_WIDTH-1:0] buf_q [FRAME_BYTES];
  logic [DATA_WIDTH-1:0] buf_d [FRAME_BYTES];
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  frame_vld_q, frame_vld_d;
  logic                  err_chk_q, err_chk_d;
  logic                  err_to_q, err_to_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                  rd_state_s;
  logic                  byte_acc_s;
  logic                  wd_en_s;
  logic                  wd_clr_s;
  logic                  wd_expire_s;
  logic [FRAME_W-1:0]    frame_pack_s;

  // Only one read in flight; the strobe is held low while in reset so the
  // FIFO never sees a read before the assembler is running.
  assign rd_state_s = (state_q == BT_FRM_HUNT) || (state_q == BT_FRM_COLLECT);
  assign fifo_r_en  = rst_n && rd_state_s && !fifo_empty && !pending_q && !fifo_data_i_vld;

  // A valid with no read outstanding is ignored.
  assign byte_acc_s = fifo_data_i_vld && pending_q;

  // Watchdog runs only while waiting on an empty FIFO inside a frame.
  assign wd_en_s  = (state_q == BT_FRM_COLLECT) && !pending_q;
  assign wd_clr_s = (state_q != BT_FRM_COLLECT) || byte_acc_s;

  bt_frame_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (wd_en_s),
    .clr    (wd_clr_s),
    .expire (wd_expire_s)
  );

  // Outstanding-read tracker: set by the strobe, cleared by the returning data.
  always_comb begin
    pending_d = pending_q;
    if (fifo_r_en) begin
      pending_d = 1'b1;
    end else if (fifo_data_i_vld) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Pack the byte buffer into the output word, header in the MSBs.
  always_comb begin
    frame_pack_s = '0;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      frame_pack_s[bt_frame_bit_lo(i, FRAME_BYTES, DATA_WIDTH) +: DATA_WIDTH] = buf_q[i];
    end
  end

  // Frame FSM next-state, datapath and output-register inputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    chk_d       = chk_q;
    buf_d       = buf_q;
    frame_d     = frame_q;
    frame_vld_d = frame_vld_q;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      BT_FRM_HUNT: begin
        if (byte_acc_s && (fifo_data_i == HEADER)) begin
          buf_d[0] = fifo_data_i;
          sum_d    = HEADER;
          idx_d    = IDX_W'(1);
          state_d  = BT_FRM_COLLECT;
        end else begin
          state_d = BT_FRM_HUNT;
        end
      end

      BT_FRM_COLLECT: begin
        if (byte_acc_s) begin
          // A header value here is plain payload; there is no resync.
          buf_d[idx_q] = fifo_data_i;
          if (idx_q < LAST_IDX) begin
            sum_d = sum_q + fifo_data_i;
            idx_d = idx_q + IDX_W'(1);
          end else begin
            chk_d   = fifo_data_i;
            state_d = BT_FRM_CHECK;
          end
        end else if (wd_expire_s) begin
          err_to_d   = 1'b1;
          drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
          idx_d      = '0;
          state_d    = BT_FRM_HUNT;
        end else begin
          state_d = BT_FRM_COLLECT;
        end
      end

      BT_FRM_CHECK: begin
        idx_d = '0;
        if (sum_q == chk_q) begin
          frame_d     = frame_pack_s;
          frame_vld_d = 1'b1;
          state_d     = BT_FRM_OUTPUT;
        end else begin
          err_chk_d  = 1'b1;
          drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
          state_d    = BT_FRM_HUNT;
        end
      end

      BT_FRM_OUTPUT: begin
        if (frame_rdy) begin
          frame_vld_d = 1'b0;
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          state_d     = BT_FRM_HUNT;
        end else begin
          state_d = BT_FRM_OUTPUT;
        end
      end

      default: begin
        frame_vld_d = 1'b0;
        idx_d       = '0;
        state_d     = BT_FRM_HUNT;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BT_FRM_HUNT;
      pending_q   <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      chk_q       <= '0;
      for (int i = 0; i < FRAME_BYTES; i++) begin
        buf_q[i] <= '0;
      end
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      chk_q       <= chk_d;
      buf_q       <= buf_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_o      = frame_q;
  assign frame_vld    = frame_vld_q;
  assign err_checksum = err_chk_q;
  assign err_timeout  = err_to_q;
  assign frame_cnt    = frame_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
